// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions. The receiver and the transmitter both take their
// default bit timing and word width from here, so the two ends of a link agree
// unless a parameter is overridden on purpose.
//   CLOCKS_PER_PULSE_DEF : clk cycles per bit period (must be >= 4)
//   BITS_PER_WORD_DEF    : data bits per frame
//   rx_state_e           : receiver FSM states
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int unsigned CLOCKS_PER_PULSE_DEF = 10;
  localparam int unsigned BITS_PER_WORD_DEF    = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_sync.sv
// -----------------------------------------------------------------------------
// uart_sync
// Two-flop synchronizer for a single asynchronous input.
// Ports:
//   clk  : clock (rising edge)
//   rstn : asynchronous active-low reset; both flops load RESET_VAL
//   d    : asynchronous input
//   q    : synchronized output (two clk cycles of latency)
// Parameter:
//   RESET_VAL : value held by both flops during reset
// -----------------------------------------------------------------------------
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receiver: 1 start bit, BITS_PER_WORD data bits LSB first, 1 stop bit,
// no parity. The start bit is confirmed at mid-bit, each data bit and the stop
// bit are sampled one full bit period after the previous sample. Received
// words are offered on a valid/ready output; reception never stalls, so a word
// that completes while the output is still occupied is dropped (overrun).
// Parameters:
//   CLOCKS_PER_PULSE : clk cycles per bit period, at least 4
//   BITS_PER_WORD    : data bits per frame
// Ports:
//   clk       : clock (rising edge)
//   rstn      : asynchronous active-low reset
//   rx        : serial line, asynchronous to clk, idles high
//   m_data    : received word
//   m_valid   : m_data holds an unconsumed word
//   m_ready   : consumer accepts m_data
//   frame_err : one-cycle pulse when a stop bit is sampled low
//   overrun   : one-cycle pulse when a completed word is dropped
// -----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_PULSE = CLOCKS_PER_PULSE_DEF,
  parameter int unsigned BITS_PER_WORD    = BITS_PER_WORD_DEF
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     rx,
  output logic [BITS_PER_WORD-1:0] m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     frame_err,
  output logic                     overrun
);

  localparam int unsigned CNT_W = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
  localparam int unsigned BIT_W = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_PULSE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS_PER_WORD - 1);

  logic rx_s;

  rx_state_e                state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [BIT_W-1:0]         bit_q, bit_d;
  logic [BITS_PER_WORD-1:0] shift_q, shift_d;
  logic [BITS_PER_WORD-1:0] data_q, data_d;
  logic                     valid_q, valid_d;
  logic                     ferr_q, ferr_d;
  logic                     ovr_q, ovr_d;
  logic                     word_done;

  // Line idles high, so the synchronizer resets to 1 to avoid a false start.
  uart_sync #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (rx),
    .q    (rx_s)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    word_done = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end

      START: begin
        // Re-check the line at mid start bit to reject short glitches.
        if (cnt_q == CNT_HALF) begin
          if (!rx_s) begin
            state_d = DATA;
            cnt_d   = '0;
            bit_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          // LSB arrives first: shift in at the top, move right.
          shift_d = BITS_PER_WORD'({rx_s, shift_q} >> 1);
          if (bit_q == BIT_LAST) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            word_done = 1'b1;
            state_d   = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      WAIT_IDLE: begin
        // A held-low line (break) must not look like a new start bit.
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Output buffer: a completion in the same cycle as a handshake refills
    // the buffer; a completion into an occupied, unaccepted buffer is dropped.
    if (word_done) begin
      if (!valid_q || m_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && m_ready) begin
      valid_d = 1'b0;
    end
  end

  assign m_data    = data_q;
  assign m_valid   = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int CPP = 10;
  localparam int BPW = 8;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           rx = 1'b1;
  logic           m_ready = 1'b1;
  logic [BPW-1:0] m_data;
  logic           m_valid;
  logic           frame_err;
  logic           overrun;

  always #5 clk = ~clk;

  uart_rx #(
    .CLOCKS_PER_PULSE(CPP),
    .BITS_PER_WORD   (BPW)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .rx        (rx),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  int errors = 0;
  int checks = 0;

  // Model state: words the consumer must see, in order, and event counters.
  logic [BPW-1:0] exp_q[$];
  int             ferr_seen  = 0;
  int             ovr_seen   = 0;
  int             words_seen = 0;
  logic [BPW-1:0] last_word  = '0;

  logic           prev_valid = 1'b0;
  logic           prev_ready = 1'b0;
  logic           prev_ferr  = 1'b0;
  logic           prev_ovr   = 1'b0;
  logic [BPW-1:0] prev_data  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Abstract frame model: a frame is a list of line levels, one per bit
  // period; the word is the data bits weighted by position (LSB first).
  function automatic logic [BPW-1:0] model_word(input logic [BPW-1:0] d);
    logic frame_bits[BPW+2];
    int   w;
    frame_bits[0] = 1'b0;
    for (int i = 0; i < BPW; i++) frame_bits[i+1] = d[i];
    frame_bits[BPW+1] = 1'b1;
    w = 0;
    for (int i = 0; i < BPW; i++) w += int'(frame_bits[i+1]) * (1 << i);
    return BPW'(w);
  endfunction

  // Compare process: sample away from the active edge.
  always @(negedge clk) begin
    if (!rstn) begin
      check("reset_outputs", 32'({m_valid, frame_err, overrun, m_data}), 32'd0);
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      prev_ferr  = 1'b0;
      prev_ovr   = 1'b0;
    end else begin
      if (m_valid && m_ready) begin
        words_seen++;
        last_word = m_data;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h expected none", m_data);
        end else begin
          check("word", 32'(m_data), 32'(exp_q.pop_front()));
        end
      end
      if (prev_valid && !prev_ready) begin
        check("hold_valid", 32'(m_valid), 32'd1);
        check("hold_data", 32'(m_data), 32'(prev_data));
      end
      if (frame_err) begin
        ferr_seen++;
        check("ferr_pulse_len", 32'(prev_ferr), 32'd0);
      end
      if (overrun) begin
        ovr_seen++;
        check("ovr_pulse_len", 32'(prev_ovr), 32'd0);
      end
      prev_valid = m_valid;
      prev_ready = m_ready;
      prev_ferr  = frame_err;
      prev_ovr   = overrun;
      prev_data  = m_data;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic v, input int periods);
    rx = v;
    tick(CPP * periods);
  endtask

  // stop_low_periods > 0 holds the stop bit low that many bit times first.
  task automatic send_frame(input logic [BPW-1:0] d, input int stop_low_periods);
    drive_bit(1'b0, 1);
    for (int i = 0; i < BPW; i++) drive_bit(d[i], 1);
    if (stop_low_periods > 0) drive_bit(1'b0, stop_low_periods);
    drive_bit(1'b1, 1);
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 400) begin
      tick(1);
      budget++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, o0, w0;

    rstn    = 1'b0;
    rx      = 1'b1;
    m_ready = 1'b1;
    tick(5);
    rstn = 1'b1;
    tick(5);
    check("idle_valid", 32'(m_valid), 32'd0);

    // Single frame.
    f0 = ferr_seen; o0 = ovr_seen; w0 = words_seen;
    exp_q.push_back(model_word(8'hA5));
    send_frame(8'hA5, 0);
    drain("a5_drain");
    check("a5_literal", 32'(last_word), 32'hA5);
    check("a5_words", 32'(words_seen - w0), 32'd1);
    check("a5_no_ferr", 32'(ferr_seen - f0), 32'd0);
    check("a5_no_ovr", 32'(ovr_seen - o0), 32'd0);

    // Back-to-back frames.
    w0 = words_seen;
    exp_q.push_back(model_word(8'hA5));
    exp_q.push_back(model_word(8'h3C));
    send_frame(8'hA5, 0);
    send_frame(8'h3C, 0);
    drain("b2b_drain");
    check("b2b_words", 32'(words_seen - w0), 32'd2);
    check("b2b_last_literal", 32'(last_word), 32'h3C);

    // Short glitch on the line.
    f0 = ferr_seen; w0 = words_seen;
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(3 * CPP);
    check("glitch_words", 32'(words_seen - w0), 32'd0);
    check("glitch_ferr", 32'(ferr_seen - f0), 32'd0);
    check("glitch_valid", 32'(m_valid), 32'd0);

    // Stop bit held low (break), then a good frame.
    f0 = ferr_seen; w0 = words_seen;
    send_frame(8'h5A, 3);
    tick(CPP);
    check("break_ferr", 32'(ferr_seen - f0), 32'd1);
    check("break_words", 32'(words_seen - w0), 32'd0);
    exp_q.push_back(model_word(8'h11));
    send_frame(8'h11, 0);
    drain("after_break_drain");
    check("after_break_literal", 32'(last_word), 32'h11);
    check("break_ferr_total", 32'(ferr_seen - f0), 32'd1);

    // Overrun with consumer stalled.
    o0 = ovr_seen; w0 = words_seen;
    m_ready = 1'b0;
    exp_q.push_back(model_word(8'h01));
    send_frame(8'h01, 0);
    send_frame(8'h02, 0);
    tick(CPP);
    check("ovr_count", 32'(ovr_seen - o0), 32'd1);
    check("ovr_valid", 32'(m_valid), 32'd1);
    check("ovr_data_literal", 32'(m_data), 32'h01);
    m_ready = 1'b1;
    drain("ovr_drain");
    tick(2);
    check("ovr_consumed_valid", 32'(m_valid), 32'd0);
    check("ovr_words", 32'(words_seen - w0), 32'd1);

    // Reset during data bit 4 of 0xFF.
    w0 = words_seen;
    drive_bit(1'b0, 1);
    drive_bit(1'b1, 4);
    tick(CPP / 2);
    rstn = 1'b0;
    rx   = 1'b1;
    tick(4);
    check("rst_mid_valid", 32'(m_valid), 32'd0);
    rstn = 1'b1;
    tick(2 * CPP);
    exp_q.push_back(model_word(8'h42));
    send_frame(8'h42, 0);
    drain("rst_drain");
    check("rst_words", 32'(words_seen - w0), 32'd1);
    check("rst_literal", 32'(last_word), 32'h42);

    tick(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
